// File: rtl/cpu_pkg.sv
// Shared core-wide constants and the IF/ID pipeline record used by the fetch stage.
package cpu_pkg;

  localparam int unsigned       PC_W      = 10;
  localparam int unsigned       INSTR_W   = 32;
  localparam logic [31:0]       RESET_PC  = 32'd0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // PC fields are stored already zero-extended to the 32-bit output width
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus1;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port, IF/ID outputs.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               stall_i;
  logic               flush_i;
  logic               redirect_i;
  logic [31:0]        redirect_target_i;
  logic [31:0]        imem_addr_o;
  logic [INSTR_W-1:0] imem_instr_i;
  logic [INSTR_W-1:0] if_id_instr_o;
  logic [31:0]        if_id_pc_o;
  logic [31:0]        if_id_pc_plus1_o;
  logic               if_id_valid_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_target_i, imem_instr_i,
    output imem_addr_o, if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, if_id_valid_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_target_i, imem_instr_i,
    input  imem_addr_o, if_id_instr_o, if_id_pc_o, if_id_pc_plus1_o, if_id_valid_o
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr    <= BUBBLE_INSTR;
      q.pc       <= '0;
      q.pc_plus1 <= '0;
      q.valid    <= 1'b0;
    end else if (bubble) begin
      // a bubble leaves the PC fields untouched so a stale link base never leaks as valid
      q.instr <= BUBBLE_INSTR;
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        PC_W      = cpu_pkg::PC_W,
  parameter logic [31:0]        RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef FETCH_PERF_EN
  output logic [31:0]    fetch_count_o,
  output logic [31:0]    stall_count_o,
`endif
  fetch_stage_if.master  bus
);

  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_plus1_p0;
  logic            capture;
  logic            hold;
  logic            bubble;
  if_id_t          if_id_d;
  if_id_t          if_id_p1;
  logic            unused_tgt_hi;

  assign pc_plus1_p0   = pc_p0 + PC_W'(1);
  assign unused_tgt_hi = ^bus.redirect_target_i[31:PC_W];

  // redirect overrides stall; flush only squashes when the pipe is moving
  assign hold    = bus.stall_i & ~bus.redirect_i;
  assign bubble  = bus.redirect_i | (bus.flush_i & ~bus.stall_i);
  assign capture = ~bus.redirect_i & ~bus.stall_i & ~bus.flush_i;

  // ---- stage 0: PC register and instruction-memory address ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC[PC_W-1:0];
    end else if (bus.redirect_i) begin
      pc_p0 <= bus.redirect_target_i[PC_W-1:0];
    end else if (!bus.stall_i) begin
      pc_p0 <= pc_plus1_p0;
    end
  end

  assign bus.imem_addr_o = 32'(pc_p0);

  always_comb begin
    if_id_d          = '0;
    if_id_d.instr    = bus.imem_instr_i;
    if_id_d.pc       = 32'(pc_p0);
    if_id_d.pc_plus1 = 32'(pc_plus1_p0);
    if_id_d.valid    = 1'b1;
  end

  // ---- stage 1: IF/ID pipeline register ----
  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (bubble),
    .d      (if_id_d),
    .q      (if_id_p1)
  );

  assign bus.if_id_instr_o    = if_id_p1.instr;
  assign bus.if_id_pc_o       = if_id_p1.pc;
  assign bus.if_id_pc_plus1_o = if_id_p1.pc_plus1;
  assign bus.if_id_valid_o    = if_id_p1.valid;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (capture) fetch_count_o <= sat_inc(fetch_count_o);
      if (hold)    stall_count_o <= sat_inc(stall_count_o);
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID state, a negedge monitor checks it.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc1;
    logic        valid;
    int          tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mem [0:1023];
  exp_t  sb_q [$];
  int    errors = 0;
  int    checks = 0;
  int    step   = 0;

  fetch_stage_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef FETCH_PERF_EN
    .fetch_count_o (fetch_count),
    .stall_count_o (stall_count),
`endif
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr_i = mem[bus.imem_addr_o[9:0]];

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("imem_addr", e.tag, bus.imem_addr_o, e.addr);
    chk("if_id_instr", e.tag, bus.if_id_instr_o, e.instr);
    chk("if_id_pc", e.tag, bus.if_id_pc_o, e.pc);
    chk("if_id_pc_plus1", e.tag, bus.if_id_pc_plus1_o, e.pc1);
    chk("if_id_valid", e.tag, {31'd0, bus.if_id_valid_o}, {31'd0, e.valid});
  endtask

  // Monitor: every negedge, consume the expectation for the edge just taken
  always @(negedge clk) begin
    if (sb_q.size() > 0) chk_all(sb_q.pop_front());
  end

  // Apply controls at negedge, take one rising edge, queue the state expected after it
  task automatic cyc(input logic s, input logic f, input logic r, input logic [31:0] tgt,
                     input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ep1, input logic ev);
    exp_t e;
    bus.stall_i = s;
    bus.flush_i = f;
    bus.redirect_i = r;
    bus.redirect_target_i = tgt;
    @(posedge clk);
    #1;
    step++;
    e.addr = ea; e.instr = ei; e.pc = ep; e.pc1 = ep1; e.valid = ev; e.tag = step;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input int tag);
    exp_t e;
    e.addr = 32'd0; e.instr = 32'h0; e.pc = 32'd0; e.pc1 = 32'd0; e.valid = 1'b0; e.tag = tag;
    chk_all(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_target_i = 32'd0;

    repeat (2) @(negedge clk);
    chk_reset_values(-1);
    rst_n = 1'b1;
    #1;
    chk("addr_after_release", 0, bus.imem_addr_o, 32'd0);

    //   s     f     r     tgt      addr   instr          pc     pc+1   valid
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd1,    32'h1000_0000, 32'd0,    32'd1,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd2,    32'h1000_0001, 32'd1,    32'd2,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd3,    32'h1000_0002, 32'd2,    32'd3,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd4,    32'h1000_0003, 32'd3,    32'd4,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd5,    32'h1000_0004, 32'd4,    32'd5,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd6,    32'h1000_0005, 32'd5,    32'd6,   1'b1);
    // two-cycle stall holding pc=5 in IF/ID
    cyc(1'b1, 1'b0, 1'b0, 32'd0,   32'd6,    32'h1000_0005, 32'd5,    32'd6,   1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0,   32'd6,    32'h1000_0005, 32'd5,    32'd6,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd7,    32'h1000_0006, 32'd6,    32'd7,   1'b1);
    // redirect to 200 from pc=7
    cyc(1'b0, 1'b0, 1'b1, 32'd200, 32'd200,  32'h0,         32'd6,    32'd7,   1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd201,  32'h1000_00C8, 32'd200,  32'd201, 1'b1);
    // redirect together with stall: redirect wins
    cyc(1'b1, 1'b0, 1'b1, 32'd40,  32'd40,   32'h0,         32'd200,  32'd201, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd41,   32'h1000_0028, 32'd40,   32'd41,  1'b1);
    // get pc to 10, then flush alone
    cyc(1'b0, 1'b0, 1'b1, 32'd10,  32'd10,   32'h0,         32'd40,   32'd41,  1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0,   32'd11,   32'h0,         32'd40,   32'd41,  1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd12,   32'h1000_000B, 32'd11,   32'd12,  1'b1);
    // wrap-around at 1023; upper target bits ignored
    cyc(1'b0, 1'b0, 1'b1, 32'hABCD_07FF, 32'd1023, 32'h0,   32'd11,   32'd12,  1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd0,    32'h1000_03FF, 32'd1023, 32'd0,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd1,    32'h1000_0000, 32'd0,    32'd1,   1'b1);
    // flush while stalled: stall holds everything
    cyc(1'b1, 1'b1, 1'b0, 32'd0,   32'd1,    32'h1000_0000, 32'd0,    32'd1,   1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd2,    32'h1000_0001, 32'd1,    32'd2,   1'b1);

    // asynchronous reset mid-cycle, with a redirect pending
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'd300;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values(100);
    @(posedge clk);
    #1;
    chk_reset_values(101);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0,   32'd1,    32'h1000_0000, 32'd0,    32'd1,   1'b1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 200, 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
